// File: rtl/commit_stream_checker.sv
// Pairs DUT and golden-model register writebacks in retirement order through two FIFOs,
// counts matches/mismatches, and latches the first compare, overflow or skew-timeout error.
module commit_stream_checker #(
    parameter int DEPTH      = 8,
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dut_wb_valid,
    input  logic [REG_ADDR_W-1:0] dut_wb_rd,
    input  logic [WORD_SIZE-1:0]  dut_wb_data,
    input  logic                  ref_wb_valid,
    input  logic [REG_ADDR_W-1:0] ref_wb_rd,
    input  logic [WORD_SIZE-1:0]  ref_wb_data,
    output logic                  cmp_valid,
    output logic                  cmp_ok,
    output logic [31:0]           match_count,
    output logic [31:0]           mismatch_count,
    output logic                  fail,
    output logic [2:0]            err_code,
    output logic [REG_ADDR_W-1:0] bad_rd_dut,
    output logic [REG_ADDR_W-1:0] bad_rd_ref,
    output logic [WORD_SIZE-1:0]  bad_data_dut,
    output logic [WORD_SIZE-1:0]  bad_data_ref,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SKEW_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_SIZE-1:0]  data;
    } entry_t;

    typedef enum logic {ST_RUN, ST_FAIL} state_t;

    // Index 0 is the DUT stream, index 1 the golden-model stream.
    entry_t           mem    [2][DEPTH];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [CNT_W-1:0] cnt    [2];
    entry_t           wb_in  [2];
    entry_t           head   [2];

    logic [1:0]        push_req, non_empty, full, push_ok, drop;
    logic              pop, rd_eq, data_eq, cmp_err, ovf_evt, skew_inc, tmo_evt;
    logic [SKEW_W-1:0] skew_cnt;
    state_t            state, state_next;
    logic [2:0]        err_next;
    logic              latch_bad;

    assign wb_in[0] = '{rd: dut_wb_rd, data: dut_wb_data};
    assign wb_in[1] = '{rd: ref_wb_rd, data: ref_wb_data};
    assign head[0]  = mem[0][rd_ptr[0]];
    assign head[1]  = mem[1][rd_ptr[1]];

    // Writes to x0 never retire architecturally, so they are filtered before the FIFO.
    assign push_req  = {ref_wb_valid && (ref_wb_rd != '0), dut_wb_valid && (dut_wb_rd != '0)};
    assign non_empty = {cnt[1] != '0, cnt[0] != '0};
    assign full      = {cnt[1] == CNT_W'(DEPTH), cnt[0] == CNT_W'(DEPTH)};
    assign pop       = &non_empty;
    assign push_ok   = push_req & (~full | {2{pop}});
    assign drop      = push_req & full & {2{~pop}};

    assign rd_eq    = (head[0].rd == head[1].rd);
    assign data_eq  = (head[0].data == head[1].data);
    assign cmp_err  = pop && !(rd_eq && data_eq);
    assign ovf_evt  = |drop;
    // Exactly one side non-empty already implies no pop this cycle.
    assign skew_inc = ^non_empty;
    assign tmo_evt  = skew_inc && (skew_cnt == SKEW_W'(TIMEOUT - 1));
    assign fail     = (state == ST_FAIL);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop)        rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                cnt[i] <= cnt[i] + CNT_W'(push_ok[i]) - CNT_W'(pop);
            end
        end
    end

    // NOTE: storage is not reset; occupancy counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_ok[i] && !reset) mem[i][wr_ptr[i]] <= wb_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skew_cnt       <= '0;
            cmp_valid      <= 1'b0;
            cmp_ok         <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            overflow       <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            if (!skew_inc)                            skew_cnt <= '0;
            else if (skew_cnt != SKEW_W'(TIMEOUT))    skew_cnt <= skew_cnt + SKEW_W'(1);
            cmp_valid <= pop;
            cmp_ok    <= pop && rd_eq && data_eq;
            if (pop && !cmp_err) match_count    <= match_count + 32'd1;
            if (cmp_err)         mismatch_count <= mismatch_count + 32'd1;
            overflow <= overflow | ovf_evt;
            timeout  <= timeout | tmo_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        err_next   = err_code;
        latch_bad  = 1'b0;
        case (state)
            ST_RUN: begin
                // Compare error outranks overflow, which outranks timeout.
                if (cmp_err) begin
                    state_next = ST_FAIL;
                    err_next   = {1'b0, !data_eq, !rd_eq};
                    latch_bad  = 1'b1;
                end else if (ovf_evt) begin
                    state_next = ST_FAIL;
                    err_next   = 3'd4;
                end else if (tmo_evt) begin
                    state_next = ST_FAIL;
                    err_next   = 3'd5;
                end
            end
            ST_FAIL: state_next = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_code     <= '0;
            bad_rd_dut   <= '0;
            bad_rd_ref   <= '0;
            bad_data_dut <= '0;
            bad_data_ref <= '0;
        end else begin
            err_code <= err_next;
            if (latch_bad) begin
                bad_rd_dut   <= head[0].rd;
                bad_rd_ref   <= head[1].rd;
                bad_data_dut <= head[0].data;
                bad_data_ref <= head[1].data;
            end
        end
    end

endmodule

// File: tb/tb_commit_stream_checker.sv
// Directed bench for commit_stream_checker: hand-computed expectations checked with
// immediate assertions, sampled 1 time unit after each rising edge.
module tb_commit_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        dut_wb_valid, ref_wb_valid;
    logic [4:0]  dut_wb_rd, ref_wb_rd;
    logic [31:0] dut_wb_data, ref_wb_data;
    logic        cmp_valid, cmp_ok, fail, overflow, timeout;
    logic [31:0] match_count, mismatch_count;
    logic [2:0]  err_code;
    logic [4:0]  bad_rd_dut, bad_rd_ref;
    logic [31:0] bad_data_dut, bad_data_ref;

    int n_vec = 0;
    int n_err = 0;

    commit_stream_checker #(.DEPTH(8), .WORD_SIZE(32), .REG_ADDR_W(5), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .dut_wb_valid(dut_wb_valid), .dut_wb_rd(dut_wb_rd), .dut_wb_data(dut_wb_data),
        .ref_wb_valid(ref_wb_valid), .ref_wb_rd(ref_wb_rd), .ref_wb_data(ref_wb_data),
        .cmp_valid(cmp_valid), .cmp_ok(cmp_ok),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .fail(fail), .err_code(err_code),
        .bad_rd_dut(bad_rd_dut), .bad_rd_ref(bad_rd_ref),
        .bad_data_dut(bad_data_dut), .bad_data_ref(bad_data_ref),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wb(input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                          input logic rv, input logic [4:0] rrd, input logic [31:0] rdd);
        dut_wb_valid = dv; dut_wb_rd = drd; dut_wb_data = dd;
        ref_wb_valid = rv; ref_wb_rd = rrd; ref_wb_data = rdd;
    endtask

    task automatic idle();
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cmp_valid"},      cmp_valid,      0);
        check({tag, ".cmp_ok"},         cmp_ok,         0);
        check({tag, ".match_count"},    match_count,    0);
        check({tag, ".mismatch_count"}, mismatch_count, 0);
        check({tag, ".fail"},           fail,           0);
        check({tag, ".err_code"},       err_code,       0);
        check({tag, ".bad_rd_dut"},     bad_rd_dut,     0);
        check({tag, ".bad_rd_ref"},     bad_rd_ref,     0);
        check({tag, ".bad_data_dut"},   bad_data_dut,   0);
        check({tag, ".bad_data_ref"},   bad_data_ref,   0);
        check({tag, ".overflow"},       overflow,       0);
        check({tag, ".timeout"},        timeout,        0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("por");

        // Identical streams: compares land one edge after the pushes.
        set_wb(1, 5'd5, 32'h0000_1234, 1, 5'd5, 32'h0000_1234);
        tick();
        check("id.no_cmp_yet", cmp_valid, 0);
        set_wb(1, 5'd7, 32'hDEAD_BEEF, 1, 5'd7, 32'hDEAD_BEEF);
        tick();
        check("id.cmp1_valid", cmp_valid, 1);
        check("id.cmp1_ok", cmp_ok, 1);
        check("id.match1", match_count, 1);
        idle();
        tick();
        check("id.cmp2_valid", cmp_valid, 1);
        check("id.cmp2_ok", cmp_ok, 1);
        check("id.match2", match_count, 2);
        tick();
        check("id.idle_valid", cmp_valid, 0);
        check("id.fail", fail, 0);

        // Skewed streams, model 4 cycles late, data mismatch on the 2nd entry.
        do_reset();
        set_wb(1, 5'd1, 32'h0000_000A, 0, 5'd0, 32'd0); tick();
        set_wb(1, 5'd9, 32'h0000_0000, 0, 5'd0, 32'd0); tick();
        set_wb(1, 5'd2, 32'h0000_000C, 0, 5'd0, 32'd0); tick();
        idle(); tick();
        set_wb(0, 5'd0, 32'd0, 1, 5'd1, 32'h0000_000A); tick();
        set_wb(0, 5'd0, 32'd0, 1, 5'd9, 32'h0000_0001); tick();
        check("sk.cmp1_ok", cmp_ok, 1);
        set_wb(0, 5'd0, 32'd0, 1, 5'd2, 32'h0000_000C); tick();
        check("sk.cmp2_valid", cmp_valid, 1);
        check("sk.cmp2_ok", cmp_ok, 0);
        check("sk.fail", fail, 1);
        check("sk.err_code", err_code, 2);
        check("sk.bad_rd_dut", bad_rd_dut, 9);
        check("sk.bad_rd_ref", bad_rd_ref, 9);
        check("sk.bad_data_dut", bad_data_dut, 32'h0);
        check("sk.bad_data_ref", bad_data_ref, 32'h1);
        idle(); tick();
        check("sk.cmp3_ok", cmp_ok, 1);
        check("sk.match", match_count, 2);
        check("sk.mismatch", mismatch_count, 1);
        check("sk.err_frozen", err_code, 2);

        // x0 filtering, rd-only mismatch.
        do_reset();
        set_wb(1, 5'd0, 32'h0000_0077, 1, 5'd4, 32'h0000_0055); tick();
        check("x0.filtered", cmp_valid, 0);
        set_wb(1, 5'd3, 32'h0000_0055, 0, 5'd0, 32'd0); tick();
        check("x0.wait", cmp_valid, 0);
        idle(); tick();
        check("rd.cmp_valid", cmp_valid, 1);
        check("rd.cmp_ok", cmp_ok, 0);
        check("rd.err_code", err_code, 1);
        check("rd.bad_rd_dut", bad_rd_dut, 3);
        check("rd.bad_rd_ref", bad_rd_ref, 4);
        check("rd.bad_data_dut", bad_data_dut, 32'h55);

        // rd and data both differ.
        do_reset();
        set_wb(1, 5'd3, 32'h1, 1, 5'd4, 32'h2); tick();
        idle(); tick();
        check("rdd.err_code", err_code, 3);

        // Nine DUT pushes into an 8-deep FIFO with no model traffic.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            set_wb(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'd0);
            tick();
        end
        check("ovf.full_no_flag", overflow, 0);
        set_wb(1, 5'd9, 32'h109, 0, 5'd0, 32'd0); tick();
        check("ovf.flag", overflow, 1);
        check("ovf.err_code", err_code, 4);
        check("ovf.fail", fail, 1);

        // Full FIFO with pop and push on the same edge: nothing is lost.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            set_wb(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'd0);
            tick();
        end
        set_wb(0, 5'd0, 32'd0, 1, 5'd1, 32'h101); tick();
        check("fpp.no_cmp", cmp_valid, 0);
        set_wb(1, 5'd9, 32'h109, 0, 5'd0, 32'd0); tick();
        check("fpp.cmp_valid", cmp_valid, 1);
        check("fpp.cmp_ok", cmp_ok, 1);
        check("fpp.no_ovf", overflow, 0);
        for (int i = 2; i <= 9; i++) begin
            set_wb(0, 5'd0, 32'd0, 1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        idle(); tick();
        check("fpp.match", match_count, 9);
        check("fpp.mismatch", mismatch_count, 0);
        check("fpp.ovf_end", overflow, 0);
        check("fpp.fail", fail, 0);

        // Timeout: one unmatched DUT entry trips the flag 64 edges after its push.
        do_reset();
        set_wb(1, 5'd1, 32'h42, 0, 5'd0, 32'd0); tick();
        idle();
        repeat (63) tick();
        check("tmo.not_yet", timeout, 0);
        tick();
        check("tmo.flag", timeout, 1);
        check("tmo.err_code", err_code, 5);
        check("tmo.fail", fail, 1);

        // A model write in time prevents the timeout.
        do_reset();
        set_wb(1, 5'd1, 32'h42, 0, 5'd0, 32'd0); tick();
        idle();
        repeat (30) tick();
        set_wb(0, 5'd0, 32'd0, 1, 5'd1, 32'h42); tick();
        idle();
        repeat (70) tick();
        check("ntmo.timeout", timeout, 0);
        check("ntmo.match", match_count, 1);
        check("ntmo.fail", fail, 0);

        // Reset mid-run with queued entries and fail set; reset-cycle writes are ignored.
        do_reset();
        set_wb(1, 5'd1, 32'h1, 1, 5'd1, 32'h2); tick();
        for (int i = 10; i < 15; i++) begin
            set_wb(1, 5'(i), 32'(i), 0, 5'd0, 32'd0);
            tick();
        end
        check("rst.pre_fail", fail, 1);
        reset = 1'b1;
        set_wb(1, 5'd5, 32'h5, 1, 5'd5, 32'h5);
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        idle(); tick();
        check("rst.no_ghost_cmp", cmp_valid, 0);
        set_wb(1, 5'd6, 32'h66, 1, 5'd6, 32'h66); tick();
        idle(); tick();
        check("rst.cmp_valid", cmp_valid, 1);
        check("rst.cmp_ok", cmp_ok, 1);
        check("rst.match", match_count, 1);
        check("rst.mismatch", mismatch_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
